// File: rtl/uart_row_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_row_loader
//
// Sits between the UART receiver and the VGA frame buffer. The module parses
// row packets sent by the host, writes the pixel bytes into the frame buffer,
// and asks the UART transmitter to send a one-byte answer for each packet.
//
// Packet layout: Y[15:8], Y[7:0], BYTE_SIZE_ROW pixel bytes, STOP_BYTE.
// Answer byte:   SUCCESSFULLY_RECEIVED for a complete, valid packet;
//                NOT_ALL_RECEIVED for a bad stop byte, out-of-range row or
//                an inter-byte gap longer than TIMEOUT_CYCLES.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   rx_data   received byte, valid while rx_done is high
//   rx_done   one-cycle receive strobe
//   tx_start  one-cycle start strobe to the transmitter
//   tx_data   answer byte, stable from tx_start until the next answer
//   tx_busy   transmitter busy
//   wr_en     frame-buffer write strobe
//   wr_row    row index of the write
//   wr_col    byte column of the write
//   wr_data   pixel byte
//   row_done  one-cycle pulse when a good packet completes
//   pkt_err   one-cycle pulse when a packet is rejected
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_row_loader #(
  parameter int          BYTE_SIZE_ROW         = 240,
  parameter int          BYTE_SIZE_Y           = 2,
  parameter logic [7:0]  STOP_BYTE             = 8'hDD,
  parameter logic [7:0]  SUCCESSFULLY_RECEIVED = 8'hFF,
  parameter logic [7:0]  NOT_ALL_RECEIVED      = 8'h11,
  parameter int          Height                = 480,
  parameter int          TIMEOUT_CYCLES        = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       wr_en,
  output logic [8:0] wr_row,
  output logic [7:0] wr_col,
  output logic [7:0] wr_data,
  output logic       row_done,
  output logic       pkt_err
);

  localparam int Y_W   = 8 * BYTE_SIZE_Y;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       COL_LAST = 8'(BYTE_SIZE_ROW - 1);
  localparam logic [Y_W-1:0]   Y_LIMIT  = Y_W'(Height);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Y_LO,
    S_ROW,
    S_STOP,
    S_ANSWER
  } state_t;

  state_t           state_reg,    state_next;
  logic [Y_W-1:0]   y_reg,        y_next;
  logic [7:0]       col_reg,      col_next;
  logic [TMO_W-1:0] tmo_reg,      tmo_next;
  logic             bad_reg,      bad_next;
  logic [7:0]       answer_reg,   answer_next;

  logic             tx_start_reg, tx_start_next;
  logic [7:0]       tx_data_reg,  tx_data_next;
  logic             wr_en_reg,    wr_en_next;
  logic [8:0]       wr_row_reg,   wr_row_next;
  logic [7:0]       wr_col_reg,   wr_col_next;
  logic [7:0]       wr_data_reg,  wr_data_next;
  logic             row_done_reg, row_done_next;
  logic             pkt_err_reg,  pkt_err_next;

  // Full row index as it will be once the low byte currently on rx_data is
  // latched; the range check needs every bit, not only the 9 used for wr_row.
  logic [Y_W-1:0]   y_full;
  assign y_full = {y_reg[Y_W-1:8], rx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      y_reg        <= '0;
      col_reg      <= '0;
      tmo_reg      <= '0;
      bad_reg      <= 1'b0;
      answer_reg   <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= '0;
      wr_en_reg    <= 1'b0;
      wr_row_reg   <= '0;
      wr_col_reg   <= '0;
      wr_data_reg  <= '0;
      row_done_reg <= 1'b0;
      pkt_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      y_reg        <= y_next;
      col_reg      <= col_next;
      tmo_reg      <= tmo_next;
      bad_reg      <= bad_next;
      answer_reg   <= answer_next;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;
      wr_en_reg    <= wr_en_next;
      wr_row_reg   <= wr_row_next;
      wr_col_reg   <= wr_col_next;
      wr_data_reg  <= wr_data_next;
      row_done_reg <= row_done_next;
      pkt_err_reg  <= pkt_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    y_next        = y_reg;
    col_next      = col_reg;
    tmo_next      = tmo_reg;
    bad_next      = bad_reg;
    answer_next   = answer_reg;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    wr_en_next    = 1'b0;
    wr_row_next   = wr_row_reg;
    wr_col_next   = wr_col_reg;
    wr_data_next  = wr_data_reg;
    row_done_next = 1'b0;
    pkt_err_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        tmo_next = '0;
        if (rx_done) begin
          y_next[Y_W-1 -: 8] = rx_data;
          col_next           = '0;
          state_next         = S_Y_LO;
        end
      end

      S_Y_LO, S_ROW, S_STOP: begin
        if (rx_done) begin
          // A byte always beats a coincident timeout.
          tmo_next = '0;
          case (state_reg)
            S_Y_LO: begin
              y_next[7:0] = rx_data;
              bad_next    = (y_full >= Y_LIMIT);
              state_next  = S_ROW;
            end
            S_ROW: begin
              if (!bad_reg) begin
                wr_en_next   = 1'b1;
                wr_row_next  = y_reg[8:0];
                wr_col_next  = col_reg;
                wr_data_next = rx_data;
              end
              col_next = col_reg + 8'd1;
              if (col_reg == COL_LAST) begin
                state_next = S_STOP;
              end
            end
            default: begin
              if (rx_data == STOP_BYTE && !bad_reg) begin
                answer_next   = SUCCESSFULLY_RECEIVED;
                row_done_next = 1'b1;
              end else begin
                answer_next  = NOT_ALL_RECEIVED;
                pkt_err_next = 1'b1;
              end
              state_next = S_ANSWER;
            end
          endcase
        end else if (tmo_reg == TMO_LAST) begin
          // Host went silent mid-packet; rows already written stay written.
          tmo_next     = '0;
          answer_next  = NOT_ALL_RECEIVED;
          pkt_err_next = 1'b1;
          state_next   = S_ANSWER;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end

      S_ANSWER: begin
        // Bytes arriving here are dropped on purpose: the host must wait
        // for the answer before sending the next row.
        tmo_next = '0;
        if (!tx_busy) begin
          tx_start_next = 1'b1;
          tx_data_next  = answer_reg;
          state_next    = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
  assign wr_en    = wr_en_reg;
  assign wr_row   = wr_row_reg;
  assign wr_col   = wr_col_reg;
  assign wr_data  = wr_data_reg;
  assign row_done = row_done_reg;
  assign pkt_err  = pkt_err_reg;

endmodule

// File: tb/tb_uart_row_loader.sv
`timescale 1ns/1ps
// Directed bench for uart_row_loader (TIMEOUT_CYCLES reduced to 1000).
module tb_uart_row_loader;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       wr_en;
  logic [8:0] wr_row;
  logic [7:0] wr_col;
  logic [7:0] wr_data;
  logic       row_done;
  logic       pkt_err;

  uart_row_loader #(
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .row_done (row_done),
    .pkt_err  (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  logic [8:0] exp_row;
  int         wr_cnt = 0, wr_bad = 0, tx_cnt = 0, rd_cnt = 0, pe_cnt = 0;
  int         tx_cyc = 0, rd_cyc = 0, pe_cyc = 0;
  logic [7:0] tx_last = 8'h00;
  logic [7:0] last_col = 8'h00;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      // Stimulus bytes equal their column, so wr_data must equal wr_col and
      // columns must run 0,1,2,... within a packet.
      if (wr_col !== wr_data || wr_row !== exp_row ||
          (wr_col != 8'd0 && wr_col != 8'(last_col + 8'd1)))
        wr_bad <= wr_bad + 1;
      last_col <= wr_col;
      wr_cnt   <= wr_cnt + 1;
    end
    if (tx_start === 1'b1) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_data;
      tx_cyc  <= cyc;
    end
    if (row_done === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
    end
    if (pkt_err === 1'b1) begin
      pe_cnt <= pe_cnt + 1;
      pe_cyc <= cyc;
    end
  end

  int total = 0;
  int fails = 0;
  int b_wr, b_bad, b_tx, b_rd, b_pe;
  int last_rx_cyc = 0;
  int t_stop, t_last, t_fall;

  task automatic check(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic snap();
    b_wr  = wr_cnt;
    b_bad = wr_bad;
    b_tx  = tx_cnt;
    b_rd  = rd_cnt;
    b_pe  = pe_cnt;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte strobe followed by one idle cycle; starts and ends at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    rx_done     = 1'b1;
    last_rx_cyc = cyc;
    tick(1);
    rx_done = 1'b0;
    tick(1);
  endtask

  task automatic send_packet(input logic [15:0] y, input int n,
                             input logic [7:0] stop, input bit with_stop);
    send_byte(y[15:8]);
    send_byte(y[7:0]);
    for (int i = 0; i < n; i++) send_byte(8'(i));
    if (with_stop) begin
      send_byte(stop);
      t_stop = last_rx_cyc;
    end
  endtask

  initial begin
    rst     = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_busy = 1'b0;
    exp_row = 9'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_start", int'(tx_start), 0);
    check("reset_wr_en",    int'(wr_en),    0);
    check("reset_outs_or",  int'(row_done | pkt_err), 0);
    check("reset_data_or",  int'(tx_data | wr_col | wr_data), 0);
    check("reset_wr_row",   int'(wr_row), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    // Good packet, Y=5
    exp_row = 9'd5;
    snap();
    send_packet(16'h0005, 240, 8'hDD, 1'b1);
    tick(4);
    check("good_writes",   wr_cnt - b_wr, 240);
    check("good_wr_bad",   wr_bad - b_bad, 0);
    check("good_last_col", int'(last_col), 239);
    check("good_row_done", rd_cnt - b_rd, 1);
    check("good_rd_time",  rd_cyc, t_stop + 1);
    check("good_pkt_err",  pe_cnt - b_pe, 0);
    check("good_tx_cnt",   tx_cnt - b_tx, 1);
    check("good_tx_data",  int'(tx_last), 8'hFF);
    check("good_tx_time",  tx_cyc, t_stop + 2);

    // Wrong stop byte, Y=1
    exp_row = 9'd1;
    snap();
    send_packet(16'h0001, 240, 8'h00, 1'b1);
    tick(4);
    check("wstop_writes",   wr_cnt - b_wr, 240);
    check("wstop_wr_bad",   wr_bad - b_bad, 0);
    check("wstop_pkt_err",  pe_cnt - b_pe, 1);
    check("wstop_row_done", rd_cnt - b_rd, 0);
    check("wstop_tx_data",  int'(tx_last), 8'h11);
    check("wstop_tx_time",  tx_cyc, t_stop + 2);

    // Out-of-range Y = 480 and Y = 0xFFFF
    snap();
    send_packet(16'h01E0, 240, 8'hDD, 1'b1);
    tick(4);
    check("y480_writes",  wr_cnt - b_wr, 0);
    check("y480_pkt_err", pe_cnt - b_pe, 1);
    check("y480_tx_data", int'(tx_last), 8'h11);
    snap();
    send_packet(16'hFFFF, 240, 8'hDD, 1'b1);
    tick(4);
    check("yffff_writes",  wr_cnt - b_wr, 0);
    check("yffff_tx_data", int'(tx_last), 8'h11);
    check("yffff_tx_cnt",  tx_cnt - b_tx, 1);

    // Timeout after 10 pixel bytes, Y=2
    exp_row = 9'd2;
    snap();
    send_packet(16'h0002, 10, 8'h00, 1'b0);
    t_last = last_rx_cyc;
    begin
      int k;
      k = 0;
      while (pe_cnt == b_pe && k < 1200) begin
        tick(1);
        k++;
      end
    end
    tick(4);
    check("tmo_pkt_err", pe_cnt - b_pe, 1);
    check("tmo_time_ok", int'((pe_cyc - t_last) >= 1000 && (pe_cyc - t_last) <= 1001), 1);
    check("tmo_writes",  wr_cnt - b_wr, 10);
    check("tmo_wr_bad",  wr_bad - b_bad, 0);
    check("tmo_tx_data", int'(tx_last), 8'h11);
    check("tmo_tx_after", int'(tx_cyc >= pe_cyc + 1), 1);
    exp_row = 9'd7;
    snap();
    send_packet(16'h0007, 240, 8'hDD, 1'b1);
    tick(4);
    check("tmo_next_writes",  wr_cnt - b_wr, 240);
    check("tmo_next_tx_data", int'(tx_last), 8'hFF);

    // Busy transmitter held across the stop byte; byte injected in ANSWER
    exp_row = 9'd9;
    snap();
    send_packet(16'h0009, 240, 8'h00, 1'b0);
    tx_busy = 1'b1;
    send_byte(8'hDD);
    t_stop = last_rx_cyc;
    tick(2);
    send_byte(8'h55);
    tick(44);
    check("busy_no_tx", tx_cnt - b_tx, 0);
    tx_busy = 1'b0;
    t_fall  = cyc;
    tick(4);
    check("busy_row_done", rd_cyc, t_stop + 1);
    check("busy_writes",   wr_cnt - b_wr, 240);
    check("busy_wr_bad",   wr_bad - b_bad, 0);
    check("busy_tx_cnt",   tx_cnt - b_tx, 1);
    check("busy_tx_time",  tx_cyc, t_fall + 1);
    check("busy_tx_data",  int'(tx_last), 8'hFF);

    // Reset after pixel byte 100, Y=3
    exp_row = 9'd3;
    snap();
    send_packet(16'h0003, 101, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_wr_row",  int'(wr_row), 0);
    check("rst_wr_col",  int'(wr_col), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_strobes", int'(wr_en | tx_start | row_done | pkt_err | (wr_data != 8'd0)), 0);
    tick(1100);
    check("rst_no_answer", tx_cnt - b_tx, 0);
    check("rst_no_err",    pe_cnt - b_pe, 0);
    check("rst_writes",    wr_cnt - b_wr, 101);
    exp_row = 9'd5;
    snap();
    send_packet(16'h0005, 240, 8'hDD, 1'b1);
    tick(4);
    check("post_rst_writes",   wr_cnt - b_wr, 240);
    check("post_rst_wr_bad",   wr_bad - b_bad, 0);
    check("post_rst_last_col", int'(last_col), 239);
    check("post_rst_tx_time",  tx_cyc, t_stop + 2);
    check("post_rst_tx_data",  int'(tx_last), 8'hFF);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
